// File: rtl/uart_port_pkg.sv
// Shared definitions for the uart_port serial path: frame constants, FSM state
// encodings and a parity helper.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit after data bit 7).
package uart_port_pkg;

    localparam int OVS       = 16;
    localparam int MID_TICK  = 7;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_port_baud_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, free-running.
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [15:0] RELOAD = 16'(DIV - 1);

    logic [15:0] cnt;

    // Down-counter, terminal count at zero reloads and produces the tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= RELOAD;
        end else if (cnt == 16'd0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

    assign tick = (cnt == 16'd0);

endmodule

// File: rtl/uart_port.sv
// uart_port: 8N1 serial transmitter and 16x oversampled receiver.
// Optional feature macro: UART_PARITY_EN (even parity, 11-bit frame).
//
// TX state  | meaning
// TX_IDLE   | line high, TX_STATUS=1, accepts TX_EN
// TX_LOAD   | byte latched, waiting for next tick to align the start bit
// TX_START  | start bit (0) for 16 ticks
// TX_DATA   | data bits LSB first, 16 ticks each
// TX_PARITY | even parity bit (UART_PARITY_EN only)
// TX_STOP   | stop bit (1) for 16 ticks
//
// RX state  | meaning
// RX_IDLE   | waiting for synchronised low level
// RX_START  | verify start bit at mid-bit, high -> false start
// RX_DATA   | sample 8 data bits at mid-bit
// RX_PARITY | sample parity bit (UART_PARITY_EN only)
// RX_STOP   | sample stop bit at mid-bit, deliver or flag error
module uart_port import uart_port_pkg::*; #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9_600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] UART_TXD,
    input  logic       TX_EN,
    output logic       TX_STATUS,
    output logic [7:0] UART_RXD,
    output logic       RX_EFF,
    input  logic       RX_READ,
    input  logic       rx_pin,
    output logic       tx_pin,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int DIV = CLK_FREQ / (BAUD * OVS);

    logic tick;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t  tx_state, tx_next;
    logic [3:0] tx_cnt;
    logic [2:0] tx_bits;
    logic [7:0] tx_shift;
    logic       tx_bit_end;
`ifdef UART_PARITY_EN
    logic       tx_par;
`endif

    assign tx_bit_end = tick && (tx_cnt == 4'd0);

    // TX state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // TX next-state logic; TX_EN outside IDLE is ignored.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (TX_EN) tx_next = TX_LOAD;
            TX_LOAD:  if (tick) tx_next = TX_START;
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
`ifdef UART_PARITY_EN
            TX_DATA:   if (tx_bit_end && tx_bits == 3'd0) tx_next = TX_PARITY;
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
`else
            TX_DATA:   if (tx_bit_end && tx_bits == 3'd0) tx_next = TX_STOP;
`endif
            TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX outputs decoded from state so reset forces the line high at once.
    always_comb begin
        tx_pin    = 1'b1;
        TX_STATUS = 1'b0;
        case (tx_state)
            TX_IDLE:   TX_STATUS = 1'b1;
            TX_START:  tx_pin = 1'b0;
            TX_DATA:   tx_pin = tx_shift[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_pin = tx_par;
`endif
            default:   tx_pin = 1'b1;
        endcase
    end

    // TX datapath: byte latch, tick down-counter, bit shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt   <= 4'(OVS - 1);
            tx_bits  <= 3'd0;
            tx_shift <= 8'h00;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            if (tx_state == TX_IDLE && TX_EN) begin
                tx_shift <= UART_TXD;
                tx_bits  <= 3'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
                tx_par   <= even_parity(UART_TXD);
`endif
            end
            if (tx_state == TX_LOAD) begin
                tx_cnt <= 4'(OVS - 1);
            end else if (tick) begin
                tx_cnt <= (tx_cnt == 4'd0) ? 4'(OVS - 1) : tx_cnt - 4'd1;
            end
            if (tx_state == TX_DATA && tx_bit_end) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bits  <= tx_bits - 3'd1;
            end
        end
    end

    // ---------------- receiver ----------------
    rx_state_t  rx_state, rx_next;
    logic       rx_meta, rx_s;
    logic [3:0] rx_cnt;
    logic [2:0] rx_bits;
    logic [7:0] rx_shift;
    logic       rx_samp, rx_good, rx_done, rx_bad;
`ifdef UART_PARITY_EN
    logic       rx_par_bad;
`endif

    // Two-flop synchroniser, idle-high reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rx_s    <= rx_meta;
        end
    end

    assign rx_samp = tick && (rx_cnt == 4'd0);

    // RX state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    // RX next-state logic; STOP returns to IDLE at mid-bit for back-to-back frames.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_s) rx_next = RX_START;
            RX_START: if (rx_samp) rx_next = rx_s ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
            RX_DATA:   if (rx_samp && rx_bits == 3'd0) rx_next = RX_PARITY;
            RX_PARITY: if (rx_samp) rx_next = RX_STOP;
`else
            RX_DATA:   if (rx_samp && rx_bits == 3'd0) rx_next = RX_STOP;
`endif
            RX_STOP:  if (rx_samp) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX frame outcome strobes at the stop-bit sample.
    always_comb begin
`ifdef UART_PARITY_EN
        rx_good = rx_s && !rx_par_bad;
`else
        rx_good = rx_s;
`endif
        rx_done = 1'b0;
        rx_bad  = 1'b0;
        if (rx_state == RX_STOP && rx_samp) begin
            rx_done = rx_good;
            rx_bad  = !rx_good;
        end
    end

    // RX datapath: counter starts at MID_TICK so the first sample lands mid start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_cnt     <= 4'(MID_TICK);
            rx_bits    <= 3'd0;
            rx_shift   <= 8'h00;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
        end else begin
            if (rx_state == RX_IDLE) begin
                rx_cnt  <= 4'(MID_TICK);
                rx_bits <= 3'(DATA_BITS - 1);
            end else if (tick) begin
                rx_cnt <= (rx_cnt == 4'd0) ? 4'(OVS - 1) : rx_cnt - 4'd1;
            end
            if (rx_state == RX_DATA && rx_samp) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bits  <= rx_bits - 3'd1;
            end
`ifdef UART_PARITY_EN
            if (rx_state == RX_PARITY && rx_samp) begin
                rx_par_bad <= rx_s ^ even_parity(rx_shift);
            end
`endif
        end
    end

    // Consumer interface: delivery beats a simultaneous RX_READ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            UART_RXD     <= 8'h00;
            RX_EFF       <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= rx_bad;
            rx_overrun   <= rx_done && RX_EFF && !RX_READ;
            if (rx_done) begin
                UART_RXD <= rx_shift;
                RX_EFF   <= 1'b1;
            end else if (RX_READ) begin
                RX_EFF   <= 1'b0;
            end
        end
    end

endmodule
